// File: rtl/spi_cmd_sequencer_if.sv
// Command and spi_serdes-facing signals of the register-access sequencer.
interface spi_cmd_sequencer_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_rw_i;
  logic [7:0]  cmd_addr_i;
  logic [7:0]  cmd_wdata_i;
  logic        start_trans_o;
  logic [15:0] send_data_o;
  logic [15:0] recv_data_i;
  logic        done_trans_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        rsp_error_o;
  logic        busy_o;

  // Sequencer view.
  modport slave (
    input  cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_wdata_i, recv_data_i, done_trans_i,
    output cmd_ready_o, start_trans_o, send_data_o, rsp_valid_o, rsp_rdata_o,
           rsp_error_o, busy_o
  );

  // Command source / spi_serdes view.
  modport master (
    output cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_wdata_i, recv_data_i, done_trans_i,
    input  cmd_ready_o, start_trans_o, send_data_o, rsp_valid_o, rsp_rdata_o,
           rsp_error_o, busy_o
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Expands one register write/read command into two 16-bit spi_serdes frames
// and returns read data or a timeout error.
module spi_cmd_sequencer #(
  parameter logic [7:0]  WRITE_CMD      = 8'h00,
  parameter logic [7:0]  READ_CMD       = 8'h01,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               sys_clock_i,
  input logic               sys_reset_i,
  spi_cmd_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_L0, S_W0, S_GAP, S_L1, S_W1, S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        start_q, start_d;
  logic [15:0] send_q, send_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;

  // Next-state, command capture, frame load, response capture and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    send_d  = send_q;
    rdata_d = rdata_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          rw_d    = bus.cmd_rw_i;
          addr_d  = bus.cmd_addr_i;
          wdata_d = bus.cmd_wdata_i;
          send_d  = {(bus.cmd_rw_i ? READ_CMD : WRITE_CMD), bus.cmd_addr_i};
          state_d = S_L0;
        end
      end
      S_L0: begin
        cnt_d   = '0;
        state_d = S_W0;
      end
      S_W0: begin
        // done takes priority over a coincident timeout
        if (bus.done_trans_i) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          rdata_d = 8'h00;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          send_d  = rw_q ? 16'h0000 : {wdata_q, 8'h00};
          state_d = S_L1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_L1: begin
        cnt_d   = '0;
        state_d = S_W1;
      end
      S_W1: begin
        if (bus.done_trans_i) begin
          error_d = 1'b0;
          rdata_d = rw_q ? bus.recv_data_i[7:0] : 8'h00;
          state_d = S_RSP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          rdata_d = 8'h00;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    start_d     = (state_d == S_L0) || (state_d == S_L1);
    rsp_valid_d = (state_d == S_RSP);
  end

  // State, counter, command fields and output registers.
  always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      cmd_ready_q <= 1'b1;
      start_q     <= 1'b0;
      send_q      <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      start_q     <= start_d;
      send_q      <= send_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready_o   = cmd_ready_q;
  assign bus.start_trans_o = start_q;
  assign bus.send_data_o   = send_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_error_o   = error_q;
  assign bus.busy_o        = busy_q;

endmodule
